// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX operand-select stage.
// ALU opcodes, widths, forwarding selects and the registered control bundle.
package id_ex_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_JMP  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SGT  = 4'd11;
  localparam logic [3:0] ALU_CLZO = 4'd12;
  localparam logic [3:0] ALU_ROTR = 4'd13;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_MEM,
    FWD_WB
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu;
    logic       alusrc;
    logic       shiftsrc;
    logic       countones;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
  } id_ex_ctl_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand bypass: picks EX/MEM, then MEM/WB, then the stored value.
// Register 0 is hard-wired zero and never bypassed.
module fwd_unit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  src_i,
  input  logic [DATA_W-1:0] val_i,
  input  logic              mem_we_i,
  input  logic [REG_W-1:0]  mem_reg_i,
  input  logic [DATA_W-1:0] mem_val_i,
  input  logic              wb_we_i,
  input  logic [REG_W-1:0]  wb_reg_i,
  input  logic [DATA_W-1:0] wb_val_i,
  output logic [DATA_W-1:0] fwd_o
);
  import id_ex_pkg::*;

  fwd_sel_e sel;
  logic     mem_hit;
  logic     wb_hit;

  assign mem_hit = mem_we_i && (mem_reg_i != '0)
                && (mem_reg_i == src_i);
  assign wb_hit  = wb_we_i && (wb_reg_i != '0)
                && (wb_reg_i == src_i);

  always_comb begin
    sel = FWD_REG;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

  always_comb begin
    unique case (sel)
      FWD_MEM: fwd_o = mem_val_i;
      FWD_WB:  fwd_o = wb_val_i;
      default: fwd_o = val_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, ALU operand select
// and load-use hazard detection.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ID_Valid,
  input  logic [3:0]        ID_ALUControl,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [4:0]        ID_Shamt,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic              ID_ALUSrc,
  input  logic              ID_ShiftSrc,
  input  logic              ID_CountOnes,
  input  logic              ID_RegDst,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic              MEM_RegWrite,
  input  logic [REG_W-1:0]  MEM_WriteReg,
  input  logic [DATA_W-1:0] MEM_Result,
  input  logic              WB_RegWrite,
  input  logic [REG_W-1:0]  WB_WriteReg,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              LoadUseStall,
  output logic              EX_Valid,
  output logic [3:0]        EX_ALUControl,
  output logic [DATA_W-1:0] EX_A,
  output logic [DATA_W-1:0] EX_B,
  output logic [DATA_W-1:0] EX_StoreData,
  output logic [REG_W-1:0]  EX_WriteReg,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_MemToReg
);
  import id_ex_pkg::*;

  id_ex_ctl_t        ctl_q, ctl_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [REG_W-1:0]  rs_q, rs_d;
  logic [REG_W-1:0]  rt_q, rt_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  fwd_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .src_i     (rs_q),
    .val_i     (rd1_q),
    .mem_we_i  (MEM_RegWrite),
    .mem_reg_i (MEM_WriteReg),
    .mem_val_i (MEM_Result),
    .wb_we_i   (WB_RegWrite),
    .wb_reg_i  (WB_WriteReg),
    .wb_val_i  (WB_Data),
    .fwd_o     (fwd_rs)
  );

  fwd_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .src_i     (rt_q),
    .val_i     (rd2_q),
    .mem_we_i  (MEM_RegWrite),
    .mem_reg_i (MEM_WriteReg),
    .mem_val_i (MEM_Result),
    .wb_we_i   (WB_RegWrite),
    .wb_reg_i  (WB_WriteReg),
    .wb_val_i  (WB_Data),
    .fwd_o     (fwd_rt)
  );

  assign LoadUseStall = ctl_q.valid && ctl_q.memread
                     && (wreg_q != '0) && ID_Valid
                     && ((wreg_q == ID_Rs) || (wreg_q == ID_Rt));

  // Held operands re-latch their bypassed value so a retiring
  // producer is not lost while the stage is frozen.
  always_comb begin
    ctl_d   = ctl_q;
    rd1_d   = fwd_rs;
    rd2_d   = fwd_rt;
    imm_d   = imm_q;
    shamt_d = shamt_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    wreg_d  = wreg_q;
    if (Flush || (!Stall && LoadUseStall)) begin
      ctl_d = '0;
    end else if (!Stall) begin
      ctl_d.valid     = ID_Valid;
      ctl_d.alu       = ID_ALUControl;
      ctl_d.alusrc    = ID_ALUSrc;
      ctl_d.shiftsrc  = ID_ShiftSrc;
      ctl_d.countones = ID_CountOnes;
      ctl_d.regwrite  = ID_RegWrite & ID_Valid;
      ctl_d.memread   = ID_MemRead & ID_Valid;
      ctl_d.memwrite  = ID_MemWrite & ID_Valid;
      ctl_d.memtoreg  = ID_MemToReg & ID_Valid;
      rd1_d   = ID_ReadData1;
      rd2_d   = ID_ReadData2;
      imm_d   = ID_Imm;
      shamt_d = ID_Shamt;
      rs_d    = ID_Rs;
      rt_d    = ID_Rt;
      wreg_d  = ID_RegDst ? ID_Rd : ID_Rt;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ctl_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      shamt_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      wreg_q  <= '0;
    end else begin
      ctl_q   <= ctl_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      shamt_q <= shamt_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wreg_q  <= wreg_d;
    end
  end

  always_comb begin
    EX_A = fwd_rs;
    EX_B = ctl_q.alusrc ? imm_q : fwd_rt;
    if (ctl_q.shiftsrc) begin
      EX_A = fwd_rt;
      EX_B = {{(DATA_W-5){1'b0}}, shamt_q};
    end else if (ctl_q.alu == ALU_CLZO) begin
      EX_B = {{(DATA_W-1){1'b0}}, ctl_q.countones};
    end
  end

  assign EX_StoreData  = fwd_rt;
  assign EX_Valid      = ctl_q.valid;
  assign EX_ALUControl = ctl_q.alu;
  assign EX_WriteReg   = wreg_q;
  assign EX_RegWrite   = ctl_q.regwrite;
  assign EX_MemRead    = ctl_q.memread;
  assign EX_MemWrite   = ctl_q.memwrite;
  assign EX_MemToReg   = ctl_q.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall, Flush, ID_Valid;
  logic [3:0]  ID_ALUControl;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm;
  logic [4:0]  ID_Shamt, ID_Rs, ID_Rt, ID_Rd;
  logic        ID_ALUSrc, ID_ShiftSrc, ID_CountOnes, ID_RegDst;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg;
  logic        MEM_RegWrite, WB_RegWrite;
  logic [4:0]  MEM_WriteReg, WB_WriteReg;
  logic [31:0] MEM_Result, WB_Data;
  logic        LoadUseStall, EX_Valid;
  logic [3:0]  EX_ALUControl;
  logic [31:0] EX_A, EX_B, EX_StoreData;
  logic [4:0]  EX_WriteReg;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  id_ex_stage dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .ID_Valid(ID_Valid), .ID_ALUControl(ID_ALUControl),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_Shamt(ID_Shamt),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_ALUSrc(ID_ALUSrc), .ID_ShiftSrc(ID_ShiftSrc),
    .ID_CountOnes(ID_CountOnes), .ID_RegDst(ID_RegDst),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg),
    .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
    .MEM_Result(MEM_Result), .WB_RegWrite(WB_RegWrite),
    .WB_WriteReg(WB_WriteReg), .WB_Data(WB_Data),
    .LoadUseStall(LoadUseStall), .EX_Valid(EX_Valid),
    .EX_ALUControl(EX_ALUControl), .EX_A(EX_A), .EX_B(EX_B),
    .EX_StoreData(EX_StoreData), .EX_WriteReg(EX_WriteReg),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite), .EX_MemToReg(EX_MemToReg)
  );

  // Model of the instruction sitting in EX.
  typedef struct {
    bit        v;
    bit [3:0]  alu;
    bit [31:0] ra, rb, imm;
    bit [4:0]  sh, rs, rt, wr;
    bit        alusrc, shs, co, rw, mr, mw, m2r;
  } ex_m_t;

  ex_m_t m;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] fwd(bit [4:0] r, bit [31:0] v);
    if (r == 0) return v;
    if (MEM_RegWrite && MEM_WriteReg == r) return MEM_Result;
    if (WB_RegWrite && WB_WriteReg == r) return WB_Data;
    return v;
  endfunction

  function automatic bit lus_of(ex_m_t c);
    return c.v && c.mr && c.wr != 0 && ID_Valid
        && (c.wr == ID_Rs || c.wr == ID_Rt);
  endfunction

  function automatic ex_m_t next_of(ex_m_t c);
    ex_m_t n = c;
    if (Flush || (!Stall && lus_of(c))) begin
      n.v = 0; n.alu = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0;
    end else if (Stall) begin
      n.ra = fwd(c.rs, c.ra);
      n.rb = fwd(c.rt, c.rb);
    end else begin
      n.v = ID_Valid; n.alu = ID_ALUControl;
      n.ra = ID_ReadData1; n.rb = ID_ReadData2; n.imm = ID_Imm;
      n.sh = ID_Shamt; n.rs = ID_Rs; n.rt = ID_Rt;
      n.wr = ID_RegDst ? ID_Rd : ID_Rt;
      n.alusrc = ID_ALUSrc; n.shs = ID_ShiftSrc; n.co = ID_CountOnes;
      n.rw = ID_RegWrite && ID_Valid;
      n.mr = ID_MemRead && ID_Valid;
      n.mw = ID_MemWrite && ID_Valid;
      n.m2r = ID_MemToReg && ID_Valid;
    end
    return n;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) m = '{default: 0};
    else m = next_of(m);
  end

  // Compare process: just before each rising edge.
  always @(negedge Clk) begin
    bit [31:0] fa, fb, ea, eb;
    #4;
    if (Rst) begin
      fa = fwd(m.rs, m.ra);
      fb = fwd(m.rt, m.rb);
      if (m.shs) begin
        ea = fb; eb = {27'b0, m.sh};
      end else if (m.alu == 4'd12) begin
        ea = fa; eb = {31'b0, m.co};
      end else begin
        ea = fa; eb = m.alusrc ? m.imm : fb;
      end
      chk("m_valid", {31'b0, EX_Valid}, {31'b0, m.v});
      chk("m_alu", {28'b0, EX_ALUControl}, {28'b0, m.alu});
      chk("m_ctl", {28'b0, EX_RegWrite, EX_MemRead, EX_MemWrite,
                    EX_MemToReg}, {28'b0, m.rw, m.mr, m.mw, m.m2r});
      chk("m_lus", {31'b0, LoadUseStall}, {31'b0, lus_of(m)});
      if (m.v) begin
        chk("m_a", EX_A, ea);
        chk("m_b", EX_B, eb);
        chk("m_sd", EX_StoreData, fb);
        chk("m_wr", {27'b0, EX_WriteReg}, {27'b0, m.wr});
      end
    end
  end

  task automatic idle();
    Stall = 0; Flush = 0; ID_Valid = 0; ID_ALUControl = 0;
    ID_ReadData1 = 0; ID_ReadData2 = 0; ID_Imm = 0; ID_Shamt = 0;
    ID_Rs = 0; ID_Rt = 0; ID_Rd = 0; ID_ALUSrc = 0; ID_ShiftSrc = 0;
    ID_CountOnes = 0; ID_RegDst = 0; ID_RegWrite = 0; ID_MemRead = 0;
    ID_MemWrite = 0; ID_MemToReg = 0;
    MEM_RegWrite = 0; MEM_WriteReg = 0; MEM_Result = 0;
    WB_RegWrite = 0; WB_WriteReg = 0; WB_Data = 0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, {31'b0, EX_Valid}, 32'd0);
    chk({tag, "_a"}, EX_A, 32'd0);
    chk({tag, "_b"}, EX_B, 32'd0);
    chk({tag, "_sd"}, EX_StoreData, 32'd0);
    chk({tag, "_alu"}, {28'b0, EX_ALUControl}, 32'd0);
    chk({tag, "_wr"}, {27'b0, EX_WriteReg}, 32'd0);
    chk({tag, "_ctl"}, {28'b0, EX_RegWrite, EX_MemRead, EX_MemWrite,
                        EX_MemToReg}, 32'd0);
  endtask

  initial begin
    bit [3:0] ops [13];
    ops = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 13};
    Rst = 0;
    idle();
    @(negedge Clk); #1;
    all_zero("reset");
    Rst = 1;

    // add rs=1(5) rt=2(7) rd=3
    @(negedge Clk);
    ID_Valid = 1; ID_ALUControl = 2; ID_ReadData1 = 5; ID_ReadData2 = 7;
    ID_Rs = 1; ID_Rt = 2; ID_Rd = 3; ID_RegDst = 1; ID_RegWrite = 1;
    @(negedge Clk); #1;
    chk("add_a", EX_A, 32'd5);
    chk("add_b", EX_B, 32'd7);
    chk("add_alu", {28'b0, EX_ALUControl}, 32'd2);
    chk("add_wr", {27'b0, EX_WriteReg}, 32'd3);
    chk("add_valid", {31'b0, EX_Valid}, 32'd1);

    // forwarding priority on rs=8
    ID_Rs = 8; ID_ReadData1 = 1; ID_Rt = 9; ID_ReadData2 = 0;
    @(negedge Clk);
    MEM_RegWrite = 1; MEM_WriteReg = 8; MEM_Result = 32'hAA;
    WB_RegWrite = 1; WB_WriteReg = 8; WB_Data = 32'hBB;
    #1 chk("fwd_mem", EX_A, 32'hAA);
    MEM_RegWrite = 0;
    #1 chk("fwd_wb", EX_A, 32'hBB);
    MEM_RegWrite = 1; MEM_WriteReg = 0; WB_WriteReg = 0;
    ID_Rs = 0; ID_ReadData1 = 32'h123;
    @(negedge Clk); #1;
    chk("fwd_r0", EX_A, 32'h123);

    // load-use: lw r4 then add using r4
    idle();
    ID_Valid = 1; ID_ALUControl = 2; ID_MemRead = 1; ID_RegWrite = 1;
    ID_MemToReg = 1; ID_ALUSrc = 1; ID_Rs = 1; ID_Rt = 4;
    @(negedge Clk);
    idle();
    ID_Valid = 1; ID_ALUControl = 2; ID_Rs = 4; ID_Rt = 5;
    ID_ReadData2 = 3; ID_RegDst = 1; ID_Rd = 6; ID_RegWrite = 1;
    #1 chk("lu_stall", {31'b0, LoadUseStall}, 32'd1);
    @(negedge Clk); #1;
    chk("lu_bubble_v", {31'b0, EX_Valid}, 32'd0);
    chk("lu_bubble_rw", {31'b0, EX_RegWrite}, 32'd0);
    MEM_RegWrite = 1; MEM_WriteReg = 4; MEM_Result = 32'h99;
    @(negedge Clk); #1;
    chk("lu_valid", {31'b0, EX_Valid}, 32'd1);
    chk("lu_fwd", EX_A, 32'h99);

    // stall while the rt producer retires
    idle();
    ID_Valid = 1; ID_ALUControl = 2; ID_Rs = 7; ID_ReadData1 = 2;
    ID_Rt = 6; ID_ReadData2 = 32'h11; ID_RegWrite = 1;
    @(negedge Clk);
    Stall = 1; ID_Rs = 3; ID_Rt = 2; ID_ReadData2 = 32'h55;
    WB_RegWrite = 1; WB_WriteReg = 6; WB_Data = 32'h42;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      WB_RegWrite = 0;
      #1 chk("stall_b", EX_B, 32'h42);
    end
    chk("stall_v", {31'b0, EX_Valid}, 32'd1);

    // flush wins over stall
    Flush = 1;
    @(negedge Clk); #1;
    chk("flush_v", {31'b0, EX_Valid}, 32'd0);
    chk("flush_alu", {28'b0, EX_ALUControl}, 32'd0);
    chk("flush_rw", {31'b0, EX_RegWrite}, 32'd0);

    // operand modes
    idle();
    ID_Valid = 1; ID_ALUControl = 10; ID_ShiftSrc = 1; ID_Shamt = 4;
    ID_Rt = 2; ID_ReadData2 = 32'hF; ID_Rs = 3; ID_ReadData1 = 32'h77;
    @(negedge Clk); #1;
    chk("sll_a", EX_A, 32'hF);
    chk("sll_b", EX_B, 32'd4);
    ID_ShiftSrc = 0; ID_ALUControl = 12; ID_CountOnes = 1;
    ID_ReadData1 = 32'h8000_0000;
    @(negedge Clk); #1;
    chk("clo_a", EX_A, 32'h8000_0000);
    chk("clo_b", EX_B, 32'd1);
    ID_CountOnes = 0; ID_ALUControl = 2; ID_ALUSrc = 1;
    ID_Imm = 32'hFFFF_FFFC;
    @(negedge Clk); #1;
    chk("addi_b", EX_B, 32'hFFFF_FFFC);

    // asynchronous reset in mid cycle
    idle();
    #1 Rst = 0;
    #1 all_zero("areset");
    chk("areset_lus", {31'b0, LoadUseStall}, 32'd0);
    @(negedge Clk);
    Rst = 1;

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge Clk);
      Stall = ($urandom_range(0, 9) == 0);
      Flush = ($urandom_range(0, 19) == 0);
      ID_Valid = ($urandom_range(0, 4) != 0);
      ID_ALUControl = ops[$urandom_range(0, 12)];
      ID_ReadData1 = $urandom; ID_ReadData2 = $urandom;
      ID_Imm = $urandom; ID_Shamt = 5'($urandom);
      ID_Rs = 5'($urandom_range(0, 7));
      ID_Rt = 5'($urandom_range(0, 7));
      ID_Rd = 5'($urandom_range(0, 7));
      ID_ALUSrc = 1'($urandom); ID_ShiftSrc = ($urandom_range(0, 4) == 0);
      ID_CountOnes = 1'($urandom); ID_RegDst = 1'($urandom);
      ID_RegWrite = 1'($urandom); ID_MemRead = ($urandom_range(0, 2) == 0);
      ID_MemWrite = 1'($urandom); ID_MemToReg = 1'($urandom);
      MEM_RegWrite = 1'($urandom); MEM_WriteReg = 5'($urandom_range(0, 7));
      MEM_Result = $urandom;
      WB_RegWrite = 1'($urandom); WB_WriteReg = 5'($urandom_range(0, 7));
      WB_Data = $urandom;
    end

    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
